// File: rtl/mem_pkg.sv
// Shared encodings for the MEM stage: access sizes, MMIO counter address, lane-mask helper.
// The MMIO_COUNTER_EN macro (see data_memory_unit.sv) consumes MMIO_CNT_ADDR.
package mem_pkg;
  typedef enum logic [1:0] {
    MEM_BYTE = 2'b00,
    MEM_HALF = 2'b01,
    MEM_WORD = 2'b10,
    MEM_RSVD = 2'b11
  } mem_size_e;

  localparam logic [31:0] MMIO_CNT_ADDR = 32'hFFFF_FFF0;

  // Byte lanes touched by an access of size sz at byte offset off.
  function automatic logic [3:0] lane_mask(mem_size_e sz, logic [1:0] off);
    logic [3:0] m;
    m = 4'b0000;
    unique case (sz)
      MEM_BYTE: m = 4'b0001 << off;
      MEM_HALF: m = off[1] ? 4'b1100 : 4'b0011;
      MEM_WORD: m = 4'b1111;
      default:  m = 4'b0000;
    endcase
    return m;
  endfunction
endpackage

// File: rtl/data_memory_unit_if.sv
// Datapath-to-memory bus: request fields from the ALU/regfile, load data and status back.
interface data_memory_unit_if;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        MemRead;
  logic        MemWrite;
  logic [1:0]  MemSize;
  logic        MemSigned;
  logic [31:0] ReadData;
  logic        AddrErr;
  logic        ErrSticky;
  logic [31:0] BadAddr;

  modport master (
    output Address, WriteData, MemRead, MemWrite, MemSize, MemSigned,
    input  ReadData, AddrErr, ErrSticky, BadAddr
  );
  modport slave (
    input  Address, WriteData, MemRead, MemWrite, MemSize, MemSigned,
    output ReadData, AddrErr, ErrSticky, BadAddr
  );
endinterface

// File: rtl/data_memory_unit_load_extend.sv
// Load formatter: picks the byte/half lane out of the addressed word and sign/zero extends it.
module load_extend
  import mem_pkg::*;
(
  input  logic [3:0][7:0] i_word,
  input  logic [1:0]      i_offset,
  input  mem_size_e       i_size,
  input  logic            i_signed,
  output logic [31:0]     o_data
);
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    o_data = '0;
    w_byte = i_word[i_offset];
    w_half = i_offset[1] ? i_word[3:2] : i_word[1:0];
    unique case (i_size)
      MEM_BYTE: o_data = {{24{i_signed & w_byte[7]}}, w_byte};
      MEM_HALF: o_data = {{16{i_signed & w_half[15]}}, w_half};
      MEM_WORD: o_data = i_word;
      default:  o_data = '0;
    endcase
  end
endmodule

// File: rtl/data_memory_unit.sv
// MIPS MEM stage: combinational loads, byte-lane clocked stores, misalignment sticky status.
// Optional macro MMIO_COUNTER_EN maps a free-running cycle counter at MMIO_CNT_ADDR.
module data_memory_unit
  import mem_pkg::*;
#(
  parameter int ADDR_BITS = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  data_memory_unit_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_BITS;

  logic [3:0][7:0]      r_mem [DEPTH];
  logic                 r_err_sticky;
  logic [31:0]          r_bad_addr;

  logic [ADDR_BITS-1:0] w_idx;
  mem_size_e            w_size;
  logic                 w_req;
  logic                 w_addr_err;
  logic [3:0][7:0]      w_rd_word;
  logic [31:0]          w_ext;
  logic                 w_mmio_hit;
  logic [31:0]          w_cnt;
  logic                 w_we;
  logic [3:0]           w_lane_en;
  logic [3:0][7:0]      w_wdata;

  assign w_idx     = bus.Address[ADDR_BITS+1:2];
  assign w_size    = mem_size_e'(bus.MemSize);
  assign w_req     = bus.MemRead | bus.MemWrite;
  assign w_rd_word = r_mem[w_idx];

  always_comb begin
    w_addr_err = 1'b0;
    unique case (w_size)
      MEM_BYTE: w_addr_err = 1'b0;
      MEM_HALF: w_addr_err = bus.Address[0];
      MEM_WORD: w_addr_err = |bus.Address[1:0];
      default:  w_addr_err = 1'b1;
    endcase
    w_addr_err = w_addr_err & w_req;
  end

  load_extend u_ext (
    .i_word   (w_rd_word),
    .i_offset (bus.Address[1:0]),
    .i_size   (w_size),
    .i_signed (bus.MemSigned),
    .o_data   (w_ext)
  );

`ifdef MMIO_COUNTER_EN
  logic [31:0] r_cnt;

  always_ff @(posedge Clk) begin
    if (Reset) r_cnt <= '0;
    else       r_cnt <= r_cnt + 32'd1;
  end

  // Only an aligned word access hits the counter; byte/half fall through to the array.
  assign w_mmio_hit = (bus.Address == MMIO_CNT_ADDR) && (w_size == MEM_WORD);
  assign w_cnt      = r_cnt;
`else
  assign w_mmio_hit = 1'b0;
  assign w_cnt      = '0;
`endif

  assign w_we      = bus.MemWrite & ~w_addr_err & ~Reset & ~w_mmio_hit;
  assign w_lane_en = w_we ? lane_mask(w_size, bus.Address[1:0]) : 4'b0000;

  // Replicate narrow store data across lanes so the lane mask alone selects what lands.
  always_comb begin
    w_wdata = bus.WriteData;
    unique case (w_size)
      MEM_BYTE: w_wdata = {4{bus.WriteData[7:0]}};
      MEM_HALF: w_wdata = {2{bus.WriteData[15:0]}};
      default:  w_wdata = bus.WriteData;
    endcase
  end

  always_ff @(posedge Clk) begin
    for (int l = 0; l < 4; l++) begin
      if (w_lane_en[l]) r_mem[w_idx][l] <= w_wdata[l];
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_err_sticky <= 1'b0;
      r_bad_addr   <= '0;
    end else if (w_addr_err && !r_err_sticky) begin
      r_err_sticky <= 1'b1;
      r_bad_addr   <= bus.Address;
    end
  end

  always_comb begin
    bus.ReadData = '0;
    if (!Reset && bus.MemRead && !w_addr_err)
      bus.ReadData = w_mmio_hit ? w_cnt : w_ext;
  end

  assign bus.AddrErr   = w_addr_err;
  assign bus.ErrSticky = r_err_sticky;
  assign bus.BadAddr   = r_bad_addr;
endmodule

// File: tb/tb_data_memory_unit.sv
// Directed bench for data_memory_unit: loads/stores, lane merging, fault status, MMIO counter.
module tb_data_memory_unit;
  import mem_pkg::*;

  logic Clk = 1'b0;
  logic Reset;
  int   tests = 0;
  int   failed = 0;

  data_memory_unit_if bus ();

  data_memory_unit #(.ADDR_BITS(8)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [1:0] sz,
                       input logic sgn, input logic [31:0] addr, input logic [31:0] wd);
    bus.MemRead   = rd;
    bus.MemWrite  = wr;
    bus.MemSize   = sz;
    bus.MemSigned = sgn;
    bus.Address   = addr;
    bus.WriteData = wd;
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    Reset = 1'b1;
    drive(1, 0, MEM_WORD, 0, 32'h10, 32'h0);
    chk("rst_readdata", bus.ReadData, 32'h0);
    tick();
    tick();
    chk("rst_sticky", {31'd0, bus.ErrSticky}, 32'd0);
    chk("rst_badaddr", bus.BadAddr, 32'h0);

    // 1: word store then load
    Reset = 1'b0;
    drive(0, 1, MEM_WORD, 0, 32'h10, 32'h8040_1234);
    chk("sw_noerr", {31'd0, bus.AddrErr}, 32'd0);
    tick();
    drive(1, 0, MEM_WORD, 0, 32'h10, 32'h0);
    chk("lw_0x10", bus.ReadData, 32'h8040_1234);
    chk("lw_noerr", {31'd0, bus.AddrErr}, 32'd0);

    // 2: sub-word loads with extension
    drive(1, 0, MEM_BYTE, 1, 32'h13, 32'h0);
    chk("lb_0x13", bus.ReadData, 32'hFFFF_FF80);
    drive(1, 0, MEM_BYTE, 0, 32'h13, 32'h0);
    chk("lbu_0x13", bus.ReadData, 32'h0000_0080);
    drive(1, 0, MEM_HALF, 1, 32'h12, 32'h0);
    chk("lh_0x12", bus.ReadData, 32'hFFFF_8040);
    drive(1, 0, MEM_HALF, 0, 32'h12, 32'h0);
    chk("lhu_0x12", bus.ReadData, 32'h0000_8040);
    drive(1, 0, MEM_HALF, 1, 32'h10, 32'h0);
    chk("lh_0x10_pos", bus.ReadData, 32'h0000_1234);
    drive(1, 0, MEM_WORD, 0, 32'h10, 32'h0);
    chk("lw_ignores_sign", bus.ReadData, 32'h8040_1234);

    // 3: byte store merges into one lane
    drive(0, 1, MEM_BYTE, 0, 32'h11, 32'h0000_00AB);
    tick();
    drive(1, 0, MEM_WORD, 0, 32'h10, 32'h0);
    chk("sb_merge", bus.ReadData, 32'h8040_AB34);

    // 4: misaligned store, sticky status
    drive(0, 1, MEM_WORD, 0, 32'h12, 32'hDEAD_BEEF);
    chk("sw_mis_err", {31'd0, bus.AddrErr}, 32'd1);
    tick();
    drive(1, 0, MEM_WORD, 0, 32'h10, 32'h0);
    chk("sticky_set", {31'd0, bus.ErrSticky}, 32'd1);
    chk("badaddr_0x12", bus.BadAddr, 32'h12);
    chk("mis_sw_nowrite", bus.ReadData, 32'h8040_AB34);
    drive(1, 0, MEM_HALF, 1, 32'h21, 32'h0);
    chk("lh_mis_err", {31'd0, bus.AddrErr}, 32'd1);
    chk("lh_mis_rd0", bus.ReadData, 32'h0);
    tick();
    chk("badaddr_held", bus.BadAddr, 32'h12);
    drive(1, 0, MEM_RSVD, 0, 32'h10, 32'h0);
    chk("rsvd_size_err", {31'd0, bus.AddrErr}, 32'd1);
    chk("rsvd_rd0", bus.ReadData, 32'h0);
    drive(0, 0, MEM_RSVD, 0, 32'h13, 32'h0);
    chk("idle_noerr", {31'd0, bus.AddrErr}, 32'd0);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    #1;
    chk("rst_clr_sticky", {31'd0, bus.ErrSticky}, 32'd0);
    chk("rst_clr_badaddr", bus.BadAddr, 32'h0);

    // 5: read-during-write shows old data
    drive(0, 1, MEM_WORD, 0, 32'h20, 32'h1111_1111);
    tick();
    drive(1, 1, MEM_WORD, 0, 32'h20, 32'h5555_AAAA);
    chk("rdw_old", bus.ReadData, 32'h1111_1111);
    tick();
    drive(1, 0, MEM_WORD, 0, 32'h20, 32'h0);
    chk("rdw_new", bus.ReadData, 32'h5555_AAAA);
    drive(0, 1, MEM_HALF, 0, 32'h22, 32'h1234_BEEF);
    tick();
    drive(1, 0, MEM_WORD, 0, 32'h420, 32'h0);
    chk("sh_alias", bus.ReadData, 32'hBEEF_AAAA);
    Reset = 1'b1;
    drive(0, 1, MEM_WORD, 0, 32'h20, 32'h0);
    tick();
    Reset = 1'b0;
    drive(1, 0, MEM_WORD, 0, 32'h20, 32'h0);
    chk("rst_blocks_sw", bus.ReadData, 32'hBEEF_AAAA);

    // 6: MMIO address
    drive(0, 1, MEM_WORD, 0, 32'h3F0, 32'hCAFE_F00D);
    tick();
`ifdef MMIO_COUNTER_EN
    Reset = 1'b1;
    drive(0, 0, MEM_WORD, 0, 32'h0, 32'h0);
    tick();
    Reset = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    drive(1, 0, MEM_WORD, 0, MMIO_CNT_ADDR, 32'h0);
    chk("cnt_10", bus.ReadData, 32'd10);
    drive(0, 1, MEM_WORD, 0, MMIO_CNT_ADDR, 32'h0BAD_0BAD);
    chk("mmio_sw_noerr", {31'd0, bus.AddrErr}, 32'd0);
    tick();
    drive(1, 0, MEM_WORD, 0, 32'h3F0, 32'h0);
    chk("mmio_sw_ignored", bus.ReadData, 32'hCAFE_F00D);
    drive(1, 0, MEM_BYTE, 0, MMIO_CNT_ADDR, 32'h0);
    chk("mmio_byte_alias", bus.ReadData, 32'h0000_000D);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    drive(1, 0, MEM_WORD, 0, MMIO_CNT_ADDR, 32'h0);
    chk("cnt_after_rst", bus.ReadData, 32'd0);
`else
    drive(1, 0, MEM_WORD, 0, MMIO_CNT_ADDR, 32'h0);
    chk("ffff0_alias_rd", bus.ReadData, 32'hCAFE_F00D);
    drive(0, 1, MEM_WORD, 0, MMIO_CNT_ADDR, 32'h0BAD_0BAD);
    tick();
    drive(1, 0, MEM_WORD, 0, 32'h3F0, 32'h0);
    chk("ffff0_alias_wr", bus.ReadData, 32'h0BAD_0BAD);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: sequence did not complete");
    $fatal(1, "timeout");
  end
endmodule
